// File: rtl/vid_palette_fade.sv
// Multi-channel CPU-writable colour palette with a two-stage video lookup
// and a frame-synchronous fade engine that scales every channel by a global level.
module vid_palette_fade #(
  parameter int W   = 4,
  parameter int NCH = 3,
  parameter int AW  = 4,
  parameter int FW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW:0]       cp_addr_0,
  input  logic [31:0]       cp_wdata_0,
  input  logic              cp_we_0,
  output logic [31:0]       cp_rdata_1,
  input  logic              vp_frame_0,
  input  logic              vp_zero_0,
  input  logic              vp_brd_0,
  input  logic [AW-1:0]     vp_brd_col_0,
  input  logic [AW-1:0]     vp_col_0,
  output logic [NCH*W-1:0]  vp_col_2
);

  localparam int CW = NCH * W;
  localparam int LW = FW + 1;
  localparam logic [LW-1:0] LMAX = {1'b1, {FW{1'b0}}};

  typedef enum logic {IDLE, FADE} state_t;

  logic [CW-1:0]  r_pal [2**AW];
  state_t         r_state;
  logic [LW-1:0]  r_level;
  logic [LW-1:0]  r_tgt;
  logic [7:0]     r_per;
  logic [7:0]     r_cnt;
  logic [31:0]    r_rdata;
  logic [CW-1:0]  r_raw1;
  logic           r_zero1;
  logic [LW-1:0]  r_lvl1;
  logic [CW-1:0]  r_out;

  logic           w_ctlSel;
  logic           w_palWe;
  logic           w_ctlWe;
  logic [LW-1:0]  w_tgt;
  logic [LW-1:0]  w_step;
  logic           w_busy;
  logic [31:0]    w_status;
  logic [AW-1:0]  w_vidIdx;
  logic [CW-1:0]  w_scaled;
  logic           w_unused;

  assign w_ctlSel = cp_addr_0[AW];
  assign w_palWe  = cp_we_0 & ~w_ctlSel;
  assign w_ctlWe  = cp_we_0 & w_ctlSel;
  assign w_tgt    = (cp_wdata_0[FW:0] > LMAX) ? LMAX : cp_wdata_0[FW:0];
  assign w_step   = (r_level < r_tgt) ? r_level + LW'(1) : r_level - LW'(1);
  assign w_busy   = (r_level != r_tgt);
  assign w_status = {15'd0, w_busy, r_per, {(8-LW){1'b0}}, r_level};
  assign w_vidIdx = vp_brd_0 ? vp_brd_col_0 : vp_col_0;
  assign w_unused = ^cp_wdata_0;

  // Palette storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (w_palWe) r_pal[cp_addr_0[AW-1:0]] <= cp_wdata_0[CW-1:0];
  end

  // Fade engine: a control write always wins over a coincident frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_level <= LMAX;
      r_tgt   <= LMAX;
      r_per   <= '0;
      r_cnt   <= '0;
    end else if (w_ctlWe) begin
      r_tgt <= w_tgt;
      r_per <= cp_wdata_0[15:8];
      r_cnt <= '0;
      if (cp_wdata_0[31]) begin
        r_level <= w_tgt;
        r_state <= IDLE;
      end else begin
        r_state <= (w_tgt != r_level) ? FADE : IDLE;
      end
    end else begin
      case (r_state)
        FADE: begin
          if (vp_frame_0) begin
            if (r_cnt == r_per) begin
              r_cnt   <= '0;
              r_level <= w_step;
              if (w_step == r_tgt) r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_ctlSel) begin
      r_rdata <= w_status;
    end else begin
      r_rdata <= {{(32-CW){1'b0}}, r_pal[cp_addr_0[AW-1:0]]};
    end
  end

  // Stage 1 captures the level alongside the colour so in-flight pixels keep it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raw1  <= '0;
      r_zero1 <= 1'b1;
      r_lvl1  <= '0;
      r_out   <= '0;
    end else begin
      r_raw1  <= r_pal[w_vidIdx];
      r_zero1 <= vp_zero_0;
      r_lvl1  <= r_level;
      r_out   <= r_zero1 ? '0 : w_scaled;
    end
  end

  always_comb begin
    w_scaled = '0;
    for (int k = 0; k < NCH; k++) begin
      w_scaled[k*W +: W] = W'(({{LW{1'b0}}, r_raw1[k*W +: W]} * {{W{1'b0}}, r_lvl1}) >> FW);
    end
  end

  assign cp_rdata_1 = r_rdata;
  assign vp_col_2   = r_out;

endmodule

// File: tb/tb_vid_palette_fade.sv
// Self-checking bench for vid_palette_fade: directed scenarios with literal
// expectations followed by randomized traffic checked against a behavioural model.
module tb_vid_palette_fade;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  cp_addr_0 = '0;
  logic [31:0] cp_wdata_0 = '0;
  logic        cp_we_0 = 1'b0;
  logic [31:0] cp_rdata_1;
  logic        vp_frame_0 = 1'b0;
  logic        vp_zero_0 = 1'b0;
  logic        vp_brd_0 = 1'b0;
  logic [3:0]  vp_brd_col_0 = '0;
  logic [3:0]  vp_col_0 = '0;
  logic [11:0] vp_col_2;

  int testsRun = 0;
  int testsFailed = 0;

  vid_palette_fade #(.W(4), .NCH(3), .AW(4), .FW(4)) dut (
    .clk(clk), .rst(rst),
    .cp_addr_0(cp_addr_0), .cp_wdata_0(cp_wdata_0), .cp_we_0(cp_we_0),
    .cp_rdata_1(cp_rdata_1),
    .vp_frame_0(vp_frame_0), .vp_zero_0(vp_zero_0), .vp_brd_0(vp_brd_0),
    .vp_brd_col_0(vp_brd_col_0), .vp_col_0(vp_col_0), .vp_col_2(vp_col_2)
  );

  always #5 clk = ~clk;

  // Behavioural model state: level/target/period/frame count as plain integers.
  int          mL, mT, mP, mCnt;
  logic [11:0] mPal [16];
  bit          mKnown [16];
  logic [11:0] s1Raw;
  bit          s1Zero, s1Known;
  int          s1L;
  logic [11:0] expVid;
  bit          expVidKnown;
  logic [31:0] expRdata;
  bit          expRdKnown;

  function automatic logic [11:0] scaleColour(logic [11:0] c, int l);
    logic [11:0] r;
    int ch;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      ch = int'((c >> (4 * k)) & 12'hF);
      r = r | (12'((ch * l) / 16) << (4 * k));
    end
    return r;
  endfunction

  function automatic logic [31:0] statusWord(int l, int t, int p);
    return ((l != t) ? 32'h0001_0000 : 32'h0) | (32'(p) << 8) | 32'(l);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compute the outputs this edge must produce, then apply the edge's effects.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      mL = 16; mT = 16; mP = 0; mCnt = 0;
      s1Raw = '0; s1Zero = 1'b1; s1Known = 1'b1; s1L = 0;
      expVid = '0; expVidKnown = 1'b1;
      expRdata = '0; expRdKnown = 1'b1;
    end else begin
      int idx;
      int a;
      int nt;
      expVid = s1Zero ? 12'h000 : scaleColour(s1Raw, s1L);
      expVidKnown = s1Zero || s1Known;
      idx = vp_brd_0 ? int'(vp_brd_col_0) : int'(vp_col_0);
      s1Raw = mPal[idx]; s1Known = mKnown[idx]; s1Zero = vp_zero_0; s1L = mL;
      a = int'(cp_addr_0[3:0]);
      if (cp_addr_0[4]) begin
        expRdata = statusWord(mL, mT, mP);
        expRdKnown = 1'b1;
      end else begin
        expRdata = {20'h0, mPal[a]};
        expRdKnown = mKnown[a];
      end
      if (cp_we_0 && !cp_addr_0[4]) begin
        mPal[a] = cp_wdata_0[11:0];
        mKnown[a] = 1'b1;
      end
      if (cp_we_0 && cp_addr_0[4]) begin
        nt = int'(cp_wdata_0[4:0]);
        mT = (nt > 16) ? 16 : nt;
        mP = int'(cp_wdata_0[15:8]);
        if (cp_wdata_0[31]) mL = mT;
        mCnt = 0;
      end else if (vp_frame_0 && mL != mT) begin
        if (mCnt == mP) begin
          mCnt = 0;
          mL = (mT > mL) ? mL + 1 : mL - 1;
        end else begin
          mCnt++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled after the edge settles.
  initial forever begin
    @(posedge clk);
    #1;
    if (expRdKnown) checkOutput("rdata", cp_rdata_1, expRdata);
    if (expVidKnown) checkOutput("vid", {20'h0, vp_col_2}, {20'h0, expVid});
  end

  task automatic cpuWrite(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cp_we_0 = 1'b1; cp_addr_0 = a; cp_wdata_0 = d;
    @(negedge clk);
    cp_we_0 = 1'b0;
  endtask

  task automatic cpuRead(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cp_we_0 = 1'b0; cp_addr_0 = a;
    @(posedge clk);
    #1 d = cp_rdata_1;
  endtask

  task automatic pixel(input logic [3:0] col, output logic [11:0] v);
    @(negedge clk);
    vp_col_0 = col; vp_zero_0 = 1'b0; vp_brd_0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 v = vp_col_2;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) vp_frame_0 = 1'b1;
      @(negedge clk) vp_frame_0 = 1'b0;
    end
  endtask

  task automatic applyStimulus();
    int r;
    @(negedge clk);
    rst = ($urandom_range(0, 599) == 0);
    r = int'($urandom_range(0, 31));
    cp_we_0 = !rst && (r < 5);
    if (r == 0) begin
      cp_addr_0  = {1'b1, 4'($urandom)};
      cp_wdata_0 = {1'($urandom_range(0, 3) == 0), 15'($urandom), 8'($urandom_range(0, 3)),
                    3'($urandom), 5'($urandom)};
    end else if (r < 5) begin
      cp_addr_0  = {1'b0, 4'($urandom)};
      cp_wdata_0 = $urandom;
    end else begin
      cp_addr_0  = 5'($urandom);
      cp_wdata_0 = $urandom;
    end
    vp_frame_0   = ($urandom_range(0, 3) == 0);
    vp_zero_0    = ($urandom_range(0, 7) == 0);
    vp_brd_0     = ($urandom_range(0, 3) == 0);
    vp_brd_col_0 = 4'($urandom);
    vp_col_0     = 4'($urandom);
  endtask

  initial begin
    logic [31:0] rd;
    logic [11:0] v;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rdata", cp_rdata_1, 32'h0);
    checkOutput("reset_vid", {20'h0, vp_col_2}, 32'h0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 16; i++) cpuWrite(5'(i), $urandom);
    cpuWrite(5'd5, 32'h0000_0F84);
    cpuWrite(5'd3, 32'h0000_0123);

    cpuRead(5'h10, rd);
    checkOutput("status_after_reset", rd, 32'h0000_0010);
    pixel(4'd5, v);
    checkOutput("entry5_full", {20'h0, v}, 32'h0000_0F84);

    cpuWrite(5'h10, 32'h8000_0008);
    pixel(4'd5, v);
    checkOutput("entry5_half", {20'h0, v}, 32'h0000_0742);
    cpuRead(5'h10, rd);
    checkOutput("status_half", rd, 32'h0000_0008);

    cpuWrite(5'h10, 32'h8000_0010);
    cpuWrite(5'h10, 32'h0000_0100);
    frames(31);
    cpuRead(5'h10, rd);
    checkOutput("fade_31", rd, 32'h0001_0101);
    frames(1);
    cpuRead(5'h10, rd);
    checkOutput("fade_32", rd, 32'h0000_0100);
    pixel(4'd5, v);
    checkOutput("fade_black", {20'h0, v}, 32'h0);

    cpuWrite(5'h10, 32'h8000_0010);
    cpuWrite(5'h10, 32'h0000_0000);
    frames(6);
    cpuRead(5'h10, rd);
    checkOutput("midfade_10", rd, 32'h0001_000A);
    @(negedge clk);
    cp_we_0 = 1'b1; cp_addr_0 = 5'h10; cp_wdata_0 = 32'h0000_0010; vp_frame_0 = 1'b1;
    @(negedge clk);
    cp_we_0 = 1'b0; vp_frame_0 = 1'b0;
    cpuRead(5'h10, rd);
    checkOutput("ctl_wins_frame", rd, 32'h0001_000A);
    frames(1);
    cpuRead(5'h10, rd);
    checkOutput("midfade_11", rd, 32'h0001_000B);
    frames(5);
    cpuRead(5'h10, rd);
    checkOutput("midfade_16", rd, 32'h0000_0010);

    @(negedge clk);
    cp_we_0 = 1'b1; cp_addr_0 = 5'd3; cp_wdata_0 = 32'h0000_0ABC; vp_col_0 = 4'd3;
    @(negedge clk);
    cp_we_0 = 1'b0;
    @(posedge clk);
    #1 checkOutput("rbw_old", {20'h0, vp_col_2}, 32'h0000_0123);
    @(posedge clk);
    #1 checkOutput("rbw_new", {20'h0, vp_col_2}, 32'h0000_0ABC);

    @(negedge clk) vp_zero_0 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("zero_forced", {20'h0, vp_col_2}, 32'h0);
    @(negedge clk);
    vp_zero_0 = 1'b0; vp_brd_0 = 1'b1; vp_brd_col_0 = 4'd5; vp_col_0 = 4'd3;
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("border_sel", {20'h0, vp_col_2}, 32'h0000_0F84);
    @(negedge clk) vp_brd_0 = 1'b0;

    cpuWrite(5'h10, 32'h8000_0010);
    cpuWrite(5'h10, 32'h0000_0000);
    frames(3);
    @(negedge clk);
    rst = 1'b1; cp_addr_0 = 5'h10; vp_col_0 = 4'd5;
    @(posedge clk);
    #1;
    checkOutput("inreset_rdata", cp_rdata_1, 32'h0);
    checkOutput("inreset_vid", {20'h0, vp_col_2}, 32'h0);
    @(negedge clk) rst = 1'b0;
    cpuRead(5'h10, rd);
    checkOutput("post_reset_status", rd, 32'h0000_0010);
    cpuRead(5'd5, rd);
    checkOutput("palette_kept", rd, 32'h0000_0F84);

    for (int i = 0; i < 3000; i++) applyStimulus();
    @(negedge clk);
    rst = 1'b0; cp_we_0 = 1'b0; vp_frame_0 = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/vid_palette_fade.md
# vid_palette_fade

Parametrised colour palette for the video output path: 2^AW entries of NCH channels × W bits, CPU-writable, with a two-stage video lookup pipeline and a frame-synchronous hardware fade engine scaling every channel by a global level. It sits between the character/attribute renderer (which supplies colour indices) and the video DAC/PHY. It replaces a single-index, no-scaling palette with a multi-channel, fade-capable one on a single clock domain.

## Interface
- W, 4, bits per colour channel
- NCH, 3, channel count; channel k at bits [k*W +: W] (channel NCH-1 in MSBs)
- AW, 4, index width; palette depth 2^AW
- FW, 4, fade fraction bits; level range 0..2^FW inclusive

- clk  in  1  single clock, CPU and video
- rst  in  1  asynchronous, active-high reset
- cp_addr_0  in  AW+1  bit AW = 0: palette entry [AW-1:0]; bit AW = 1: control register (low bits ignored)
- cp_wdata_0  in  32  write data
- cp_we_0  in  1  write strobe
- cp_rdata_1  out  32  read data, one cycle after address
- vp_frame_0  in  1  one-cycle pulse per frame (vblank start)
- vp_zero_0  in  1  force black
- vp_brd_0  in  1  select border index instead of vp_col_0
- vp_brd_col_0  in  AW  border colour index
- vp_col_0  in  AW  pixel colour index
- vp_col_2  out  NCH*W  scaled colour, two cycles after inputs

## Operation
- Palette write: cp_we_0 with bit AW = 0 stores cp_wdata_0[NCH*W-1:0]. Palette RAM is not reset.
- Control write (bit AW = 1): target T <= min(wdata[FW:0], 2^FW); period P <= wdata[15:8]; if wdata[31], level L <= clamped T immediately. Any control write clears the frame counter.
- Read: palette address returns entry zero-extended to 32 bits; control address returns {15'b0, busy at [16], P at [15:8], 3'b0... L at [FW:0]}, all unused bits 0.
- busy = (L != T).
- Fade FSM, states IDLE (L == T) and FADE (L != T):
  - FADE: on each vp_frame_0, if frame counter == P, counter <= 0 and L steps by 1 toward T; else counter increments. Step period is therefore P+1 frames.
  - IDLE: frame counter held at 0; vp_frame_0 ignored.
  - FADE -> IDLE when L reaches T; IDLE -> FADE on a control write that sets T != L.
- Video stage 1: register raw = palette[vp_brd_0 ? vp_brd_col_0 : vp_col_0], zero flag, and current L.
- Video stage 2: per channel, out = (c * L) >> FW. The product is W+FW+1 bits; keep bits [W+FW-1:FW]. L = 2^FW yields c exactly, with no overflow. A zero flag forces 0 regardless of L.
- Reset values: cp_rdata_1 = 0, vp_col_2 = 0, L = T = 2^FW, P = 0, frame counter = 0, FSM IDLE.

## Timing
- CPU read latency 1; writes take effect on the next edge.
- Video latency fixed at 2 cycles; a new pixel is accepted every cycle.
- Same-cycle CPU write and video read of the same entry: video gets the old value (read-before-write). CPU read of the address being written also returns the old value.
- Control write coincident with vp_frame_0: control write wins, counter cleared, no step that cycle.
- Level change is visible to pixels entering stage 1 on the cycle after the update. Pixels already in stage 2 keep their captured L.
- Reset asserted mid-fade: immediate return to reset values; the pipeline output reads 0 until 2 cycles after deassertion with valid input.

## Test plan
- Write entry 5 = 0xF84, drive vp_col_0 = 5 -> vp_col_2 = 0xF84 exactly 2 cycles later, with L = 16 after reset.
- Control write 0x8000_0008 (immediate, T = 8) -> entry 5 outputs 0x742; status reads L = 8, busy = 0.
- From L = 16, write T = 0, P = 1 -> L decrements every 2nd vp_frame_0; after 31 pulses L = 1 and busy = 1; after 32 pulses L = 0, busy = 0, output 0x000.
- Mid-fade (L = 10, heading to 0), write T = 16, P = 0 in the same cycle as vp_frame_0 -> no step that frame; subsequent frames give 11, 12, ... 16, then IDLE.
- Write entry 3 while vp_col_0 = 3 in the same cycle -> that pixel shows the old value, the next pixel shows the new one. vp_zero_0 = 1 gives 0x000; vp_brd_0 = 1 with vp_brd_col_0 = 5 gives entry 5 scaled.
- Assert rst during a fade -> L = 16, busy = 0, vp_col_2 = 0, cp_rdata_1 = 0 while in reset; palette contents written before reset remain readable afterwards.
